// File: rtl/w_stage_grf_if.sv
// Bundle of the W-stage instruction fields, the two D-stage read ports
// and the retire log, shared between the writeback/GRF block and its driver.
interface w_stage_grf_if;
    logic        W_valid;
    logic [31:0] W_PC;
    logic        W_RegWrite;
    logic [4:0]  W_GRF_A3;
    logic [1:0]  W_WD_sel;
    logic [31:0] W_ALU_ans;
    logic [31:0] W_DM_out;
    logic [2:0]  W_load_type;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [31:0] D_RD1;
    logic [31:0] D_RD2;
    logic        log_valid;
    logic [31:0] log_pc;
    logic [4:0]  log_addr;
    logic [31:0] log_data;

    modport master (
        output W_valid, W_PC, W_RegWrite, W_GRF_A3, W_WD_sel,
               W_ALU_ans, W_DM_out, W_load_type, D_rs, D_rt,
        input  D_RD1, D_RD2, log_valid, log_pc, log_addr, log_data
    );

    modport slave (
        input  W_valid, W_PC, W_RegWrite, W_GRF_A3, W_WD_sel,
               W_ALU_ans, W_DM_out, W_load_type, D_rs, D_rt,
        output D_RD1, D_RD2, log_valid, log_pc, log_addr, log_data
    );
endinterface

// File: rtl/w_stage_grf.sv
// Writeback stage and 32x32 general register file of the MIPS pipeline.
// Selects and extends the writeback value, writes the GRF, serves two
// read ports with same-cycle write bypass, logs each write one cycle later
// and counts retired instructions.
module w_stage_grf #(
    parameter logic [31:0] LINK_OFFSET = 32'd8,
    parameter int          CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    w_stage_grf_if.slave         bus,
    output logic [CNT_WIDTH-1:0] retired_cnt
);

    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    // Extract the addressed byte/halfword from the aligned word and extend it.
    // Halfword selection only looks at off[1]; misalignment is trapped upstream.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  ltype);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic signed [31:0] ext_s;
        logic [31:0]        res;
        case (off)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            default: byte_s = word[31:24];
        endcase
        half_s = off[1] ? word[31:16] : word[15:0];
        ext_s  = '0;
        case (ltype)
            LT_LB: begin
                ext_s = byte_s;
                res   = ext_s;
            end
            LT_LBU:  res = {24'd0, byte_s};
            LT_LH: begin
                ext_s = half_s;
                res   = ext_s;
            end
            LT_LHU:  res = {16'd0, half_s};
            default: res = word;
        endcase
        return res;
    endfunction

    logic [31:0]          wd;
    logic                 we;
    logic [31:0]          regs_q [32];
    logic [31:0]          regs_d [32];
    logic                 log_valid_q, log_valid_d;
    logic [31:0]          log_pc_q, log_pc_d;
    logic [4:0]           log_addr_q, log_addr_d;
    logic [31:0]          log_data_q, log_data_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Writeback value select: ALU result, extended load data, or link address.
    always_comb begin
        wd = '0;
        case (bus.W_WD_sel)
            2'd0:    wd = bus.W_ALU_ans;
            2'd1:    wd = load_extract(bus.W_DM_out, bus.W_ALU_ans[1:0], bus.W_load_type);
            2'd2:    wd = bus.W_PC + LINK_OFFSET;
            default: wd = '0;
        endcase
    end

    // $0 is hard-wired, so a write to it is dropped entirely (no log either).
    assign we = bus.W_valid & bus.W_RegWrite & (bus.W_GRF_A3 != 5'd0);

    // Next register-file contents.
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[bus.W_GRF_A3] = wd;
        end
    end

    // Read port 1 with bypass of the value being written this cycle.
    always_comb begin
        bus.D_RD1 = regs_q[bus.D_rs];
        if (bus.D_rs == 5'd0) begin
            bus.D_RD1 = '0;
        end else if (we && (bus.D_rs == bus.W_GRF_A3)) begin
            bus.D_RD1 = wd;
        end
    end

    // Read port 2 with bypass of the value being written this cycle.
    always_comb begin
        bus.D_RD2 = regs_q[bus.D_rt];
        if (bus.D_rt == 5'd0) begin
            bus.D_RD2 = '0;
        end else if (we && (bus.D_rt == bus.W_GRF_A3)) begin
            bus.D_RD2 = wd;
        end
    end

    // Retire log and instruction counter next state; log fields hold when idle.
    always_comb begin
        log_valid_d = we;
        log_pc_d    = log_pc_q;
        log_addr_d  = log_addr_q;
        log_data_d  = log_data_q;
        cnt_d       = cnt_q;
        if (we) begin
            log_pc_d   = bus.W_PC;
            log_addr_d = bus.W_GRF_A3;
            log_data_d = wd;
        end
        if (bus.W_valid) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // State registers; reset discards whatever instruction is in W.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q      <= '{default: '0};
            log_valid_q <= 1'b0;
            log_pc_q    <= '0;
            log_addr_q  <= '0;
            log_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            regs_q      <= regs_d;
            log_valid_q <= log_valid_d;
            log_pc_q    <= log_pc_d;
            log_addr_q  <= log_addr_d;
            log_data_q  <= log_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.log_valid = log_valid_q;
    assign bus.log_pc    = log_pc_q;
    assign bus.log_addr  = log_addr_q;
    assign bus.log_data  = log_data_q;
    assign retired_cnt   = cnt_q;

endmodule

// File: tb/tb_w_stage_grf.sv
// Bench for w_stage_grf: directed table of writeback vectors, hand-written
// reset/bubble/counter sequences and a randomized run against a reference
// model of the register file, log and counter.
module tb_w_stage_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ret_cnt;
    logic [2:0]  ret_cnt_s;

    int errors = 0;
    int checks = 0;

    w_stage_grf_if ifc ();
    w_stage_grf_if ifc_s ();

    w_stage_grf #(.LINK_OFFSET(32'd8), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .bus(ifc.slave), .retired_cnt(ret_cnt)
    );

    // Narrow-counter copy fed identical stimulus, used to observe wrap-around.
    w_stage_grf #(.LINK_OFFSET(32'd8), .CNT_WIDTH(3)) dut_s (
        .clk(clk), .reset(reset), .bus(ifc_s.slave), .retired_cnt(ret_cnt_s)
    );

    assign ifc_s.W_valid     = ifc.W_valid;
    assign ifc_s.W_PC        = ifc.W_PC;
    assign ifc_s.W_RegWrite  = ifc.W_RegWrite;
    assign ifc_s.W_GRF_A3    = ifc.W_GRF_A3;
    assign ifc_s.W_WD_sel    = ifc.W_WD_sel;
    assign ifc_s.W_ALU_ans   = ifc.W_ALU_ans;
    assign ifc_s.W_DM_out    = ifc.W_DM_out;
    assign ifc_s.W_load_type = ifc.W_load_type;
    assign ifc_s.D_rs        = ifc.D_rs;
    assign ifc_s.D_rt        = ifc.D_rt;

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_grf [32];
    logic        m_log_valid;
    logic [31:0] m_log_pc;
    logic [4:0]  m_log_addr;
    logic [31:0] m_log_data;
    int unsigned m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] dm, input int off, input int lt);
        int unsigned b, h;
        b = (dm >> (8 * off)) & 32'hFF;
        h = (dm >> (16 * (off / 2))) & 32'hFFFF;
        case (lt)
            1: return (b >= 128) ? (b - 256) : b;
            2: return b;
            3: return (h >= 32768) ? (h - 65536) : h;
            4: return h;
            default: return dm;
        endcase
    endfunction

    function automatic logic [31:0] m_wd();
        case (ifc.W_WD_sel)
            2'd0: return ifc.W_ALU_ans;
            2'd1: return m_load(ifc.W_DM_out, int'(ifc.W_ALU_ans % 4), int'(ifc.W_load_type));
            2'd2: return ifc.W_PC + 32'd8;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_we();
        return ifc.W_valid && ifc.W_RegWrite && ifc.W_GRF_A3 != 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (m_we() && a == ifc.W_GRF_A3) return m_wd();
        return m_grf[a];
    endfunction

    // One clock: check read ports before the edge, advance model, check state after.
    task automatic tick();
        bit          we;
        logic [31:0] wd;
        #1;
        we = m_we();
        wd = m_wd();
        chk("rd1", ifc.D_RD1, m_read(ifc.D_rs));
        chk("rd2", ifc.D_RD2, m_read(ifc.D_rt));
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_grf[i] = 32'd0;
            m_log_valid = 1'b0;
            m_log_pc    = 32'd0;
            m_log_addr  = 5'd0;
            m_log_data  = 32'd0;
            m_cnt       = 0;
        end else begin
            if (ifc.W_valid) m_cnt++;
            m_log_valid = we;
            if (we) begin
                m_grf[ifc.W_GRF_A3] = wd;
                m_log_pc   = ifc.W_PC;
                m_log_addr = ifc.W_GRF_A3;
                m_log_data = wd;
            end
        end
        #1;
        chk("log_valid", {31'd0, ifc.log_valid}, {31'd0, m_log_valid});
        chk("log_pc", ifc.log_pc, m_log_pc);
        chk("log_addr", {27'd0, ifc.log_addr}, {27'd0, m_log_addr});
        chk("log_data", ifc.log_data, m_log_data);
        chk("retired_cnt", ret_cnt, m_cnt);
        chk("retired_cnt_w3", {29'd0, ret_cnt_s}, m_cnt % 8);
    endtask

    task automatic idle();
        ifc.W_valid     = 1'b0;
        ifc.W_PC        = 32'd0;
        ifc.W_RegWrite  = 1'b0;
        ifc.W_GRF_A3    = 5'd0;
        ifc.W_WD_sel    = 2'd0;
        ifc.W_ALU_ans   = 32'd0;
        ifc.W_DM_out    = 32'd0;
        ifc.W_load_type = 3'd0;
        ifc.D_rs        = 5'd0;
        ifc.D_rt        = 5'd0;
    endtask

    task automatic write_alu(input logic [4:0] a3, input logic [31:0] val);
        idle();
        ifc.W_valid    = 1'b1;
        ifc.W_RegWrite = 1'b1;
        ifc.W_GRF_A3   = a3;
        ifc.W_ALU_ans  = val;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [1:0]  sel;
        logic [4:0]  a3;
        logic [31:0] alu;
        logic [31:0] dm;
        logic [2:0]  lt;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];
    int   pulses;

    initial begin
        tbl[0] = '{"lb_off3",   32'h100, 2'd1, 5'd1,  32'h3,        32'h80FF7F01, 3'd1, 32'hFFFFFF80};
        tbl[1] = '{"lbu_off3",  32'h104, 2'd1, 5'd2,  32'h3,        32'h80FF7F01, 3'd2, 32'h00000080};
        tbl[2] = '{"lb_off1",   32'h108, 2'd1, 5'd3,  32'h1,        32'h80FF7F01, 3'd1, 32'h0000007F};
        tbl[3] = '{"lh_off2",   32'h10C, 2'd1, 5'd4,  32'h2,        32'h80FF7F01, 3'd3, 32'hFFFF80FF};
        tbl[4] = '{"lhu_off0",  32'h110, 2'd1, 5'd6,  32'h0,        32'h80FF7F01, 3'd4, 32'h00007F01};
        tbl[5] = '{"lw",        32'h114, 2'd1, 5'd7,  32'h0,        32'h80FF7F01, 3'd0, 32'h80FF7F01};
        tbl[6] = '{"link",      32'h3000, 2'd2, 5'd31, 32'h55,      32'h0,        3'd0, 32'h00003008};
        tbl[7] = '{"link_wrap", 32'hFFFFFFFC, 2'd2, 5'd31, 32'h0,   32'h0,        3'd0, 32'h00000004};
        tbl[8] = '{"bypass_alu", 32'h118, 2'd0, 5'd8, 32'hDEADBEEF, 32'h0,        3'd0, 32'hDEADBEEF};
        tbl[9] = '{"sel_rsvd",  32'h11C, 2'd3, 5'd9,  32'h12345678, 32'hFFFFFFFF, 3'd0, 32'h00000000};

        for (int i = 0; i < 32; i++) m_grf[i] = 32'd0;
        m_log_valid = 1'b0; m_log_pc = 32'd0; m_log_addr = 5'd0; m_log_data = 32'd0; m_cnt = 0;

        // Bring the DUT out of its power-up state with a write held under reset.
        write_alu(5'd5, 32'h1234);
        reset = 1'b1;
        @(posedge clk);
        #1;
        tick();
        reset = 1'b0;
        idle();
        ifc.D_rs = 5'd5;
        #1;
        chk("reset_rd5", ifc.D_RD1, 32'd0);
        chk("reset_cnt", ret_cnt, 32'd0);
        chk("reset_logv", {31'd0, ifc.log_valid}, 32'd0);

        write_alu(5'd5, 32'h1234);
        tick();
        chk("post_reset_logv", {31'd0, ifc.log_valid}, 32'd1);
        chk("post_reset_addr", {27'd0, ifc.log_addr}, 32'd5);
        chk("post_reset_data", ifc.log_data, 32'h00001234);
        idle();
        ifc.D_rs = 5'd5;
        #1;
        chk("post_reset_rd5", ifc.D_RD1, 32'h00001234);

        // Table of writeback vectors: bypassed value before the edge, log after.
        for (int i = 0; i < 10; i++) begin
            idle();
            ifc.W_valid     = 1'b1;
            ifc.W_RegWrite  = 1'b1;
            ifc.W_PC        = tbl[i].pc;
            ifc.W_WD_sel    = tbl[i].sel;
            ifc.W_GRF_A3    = tbl[i].a3;
            ifc.W_ALU_ans   = tbl[i].alu;
            ifc.W_DM_out    = tbl[i].dm;
            ifc.W_load_type = tbl[i].lt;
            ifc.D_rs        = tbl[i].a3;
            ifc.D_rt        = tbl[i].a3;
            #1;
            chk({tbl[i].name, "_rd1"}, ifc.D_RD1, tbl[i].exp);
            chk({tbl[i].name, "_rd2"}, ifc.D_RD2, tbl[i].exp);
            tick();
            chk({tbl[i].name, "_log"}, ifc.log_data, tbl[i].exp);
            chk({tbl[i].name, "_logpc"}, ifc.log_pc, tbl[i].pc);
            chk({tbl[i].name, "_logaddr"}, {27'd0, ifc.log_addr}, {27'd0, tbl[i].a3});
        end
        idle();
        ifc.D_rs = 5'd31;
        ifc.D_rt = 5'd8;
        #1;
        chk("grf31", ifc.D_RD1, 32'h00000004);
        chk("grf8", ifc.D_RD2, 32'hDEADBEEF);

        // Write to $0 is suppressed: reads 0, no log.
        write_alu(5'd0, 32'hCAFEF00D);
        ifc.D_rs = 5'd0;
        #1;
        chk("a3zero_rd1", ifc.D_RD1, 32'd0);
        tick();
        chk("a3zero_nolog", {31'd0, ifc.log_valid}, 32'd0);

        // Alternating bubbles: 5 retired, 5 log pulses.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            write_alu(5'd10 + 5'(i), 32'(i + 100));
            ifc.W_valid = (i % 2 == 0);
            tick();
            if (ifc.log_valid) pulses++;
        end
        chk("alt_pulses", pulses, 32'd5);
        chk("alt_cnt", ret_cnt, 32'd5);

        // Store-like instruction: counted, not logged.
        idle();
        ifc.W_valid = 1'b1;
        ifc.W_GRF_A3 = 5'd12;
        tick();
        chk("sw_cnt", ret_cnt, 32'd6);
        chk("sw_nolog", {31'd0, ifc.log_valid}, 32'd0);

        // Counter wrap on the 3-bit instance.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            idle();
            ifc.W_valid = 1'b1;
            tick();
        end
        chk("w3_cnt7", {29'd0, ret_cnt_s}, 32'd7);
        idle();
        ifc.W_valid = 1'b1;
        tick();
        chk("w3_wrap", {29'd0, ret_cnt_s}, 32'd0);
        chk("w32_cnt8", ret_cnt, 32'd8);

        // Reset concurrent with a valid write to $9.
        write_alu(5'd9, 32'h99999999);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_logv", {31'd0, ifc.log_valid}, 32'd0);
        idle();
        ifc.D_rs = 5'd9;
        #1;
        chk("midrst_rd9", ifc.D_RD1, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            ifc.W_valid     = ($urandom_range(0, 3) != 0);
            ifc.W_PC        = $urandom;
            ifc.W_RegWrite  = 1'($urandom_range(0, 1));
            ifc.W_GRF_A3    = 5'($urandom_range(0, 7));
            ifc.W_WD_sel    = 2'($urandom_range(0, 3));
            ifc.W_ALU_ans   = $urandom;
            ifc.W_DM_out    = $urandom;
            ifc.W_load_type = 3'($urandom_range(0, 7));
            ifc.D_rs        = 5'($urandom_range(0, 7));
            ifc.D_rt        = 5'($urandom_range(0, 7));
            reset           = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
